// File: rtl/reg_file_param_pkg.sv
// reg_file_pkg: shared register-file state encoding and default geometry.
package reg_file_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    typedef enum logic {CLEAR, RUN} rf_state_e;
endpackage

// File: rtl/reg_file_param.sv
// reg_file_param: 2R1W register file with registered reads, write bypass,
// optional hardwired r0 and a post-reset clear sweep gating ready.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writedata,
    input  logic              write,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              ready
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs [DEPTH];
    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, wa;
    logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d, wd;
    logic              ready_q, ready_d, we, wr_ok, last;
    always_comb begin
        last    = ptr_q == '1;
        wr_ok   = write && !(ZERO_REG && rd == '0);
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        reg1_d  = '0;
        reg2_d  = '0;
        we      = 1'b0;
        wa      = ptr_q;
        wd      = '0;
        if (state_q == CLEAR) begin
            we      = 1'b1;
            ptr_d   = last ? '0 : ptr_q + 1'b1;
            state_d = last ? RUN : CLEAR;
            ready_d = last;
        end else begin
            we      = wr_ok;
            wa      = rd;
            wd      = writedata;
            reg1_d  = (ZERO_REG && rs1 == '0) ? '0 : (wr_ok && rd == rs1) ? writedata : regs[rs1];
            reg2_d  = (ZERO_REG && rs2 == '0) ? '0 : (wr_ok && rd == rs2) ? writedata : regs[rs2];
        end
    end
    // The array has no reset; the clear sweep puts it in a known state instead.
    always_ff @(posedge clock)
        if (!reset && we) regs[wa] <= wd;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            ready_q <= ready_d;
        end
    end
    assign reg1  = reg1_q;
    assign reg2  = reg2_q;
    assign ready = ready_q;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of clear sweep, bypass, r0 handling and wide config.
module tb_reg_file_param;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [15:0] wdata = '0;
    logic        write = 1'b0;
    logic [15:0] z_reg1, z_reg2, n_reg1, n_reg2;
    logic        z_ready, n_ready;
    logic [4:0]  w_rs1 = '0, w_rs2 = '0, w_rd = '0;
    logic [31:0] w_wdata = '0, w_reg1, w_reg2;
    logic        w_write = 1'b0, w_ready;
    int total = 0, bad = 0;

    always #5 clock = ~clock;

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) u_z (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .writedata(wdata),
        .write(write), .reg1(z_reg1), .reg2(z_reg2), .ready(z_ready));
    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0)) u_n (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .writedata(wdata),
        .write(write), .reg1(n_reg1), .reg2(n_reg2), .ready(n_ready));
    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) u_w (
        .clock(clock), .reset(reset), .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .writedata(w_wdata),
        .write(w_write), .reg1(w_reg1), .reg2(w_reg2), .ready(w_ready));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_reg1", {16'h0, z_reg1}, 32'h0);
        check("rst_reg2", {16'h0, n_reg2}, 32'h0);
        check("rst_ready", {31'h0, z_ready}, 32'h0);
        check("rst_ready_w", {31'h0, w_ready}, 32'h0);
        // write attempted throughout the sweep must be ignored
        reset = 1'b0; write = 1'b1; rd = 4'd3; wdata = 16'hAAAA; rs1 = 4'd3; rs2 = 4'd3;
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("clr_ready_z%0d", i), {31'h0, z_ready}, {31'h0, i >= 16});
            check($sformatf("clr_ready_w%0d", i), {31'h0, w_ready}, {31'h0, i >= 32});
            if (i <= 16) check($sformatf("clr_reg1_%0d", i), {16'h0, n_reg1}, 32'h0);
            if (i == 16) write = 1'b0;
        end
        for (int a = 0; a < 16; a++) begin
            rs1 = 4'(a); rs2 = 4'(a);
            tick();
            check($sformatf("zero_n1_%0d", a), {16'h0, n_reg1}, 32'h0);
            check($sformatf("zero_z2_%0d", a), {16'h0, z_reg2}, 32'h0);
        end
        write = 1'b1; rd = 4'd5; wdata = 16'hBEEF; rs1 = 4'd5; rs2 = 4'd1;
        tick();
        check("byp_r5", {16'h0, z_reg1}, 32'hBEEF);
        check("byp_r1", {16'h0, z_reg2}, 32'h0);
        write = 1'b0; rs2 = 4'd5;
        tick();
        check("arr_r5", {16'h0, z_reg2}, 32'hBEEF);
        write = 1'b1; rd = 4'd0; wdata = 16'h1234; rs1 = 4'd0;
        tick();
        check("r0_byp_z", {16'h0, z_reg1}, 32'h0);
        check("r0_byp_n", {16'h0, n_reg1}, 32'h1234);
        write = 1'b0; rs2 = 4'd0;
        tick();
        check("r0_arr_z", {16'h0, z_reg2}, 32'h0);
        check("r0_arr_n", {16'h0, n_reg2}, 32'h1234);
        write = 1'b1; rd = 4'd7; wdata = 16'h7777; rs1 = 4'd7; rs2 = 4'd7;
        tick();
        check("dual_byp1", {16'h0, n_reg1}, 32'h7777);
        check("dual_byp2", {16'h0, n_reg2}, 32'h7777);
        write = 1'b0;
        w_write = 1'b1; w_rd = 5'd31; w_wdata = 32'hDEADBEEF; w_rs1 = 5'd31; w_rs2 = 5'd0;
        tick();
        check("w_byp", w_reg1, 32'hDEADBEEF);
        check("w_r0", w_reg2, 32'h0);
        w_write = 1'b0; w_rs2 = 5'd31;
        tick();
        check("w_arr1", w_reg1, 32'hDEADBEEF);
        check("w_arr2", w_reg2, 32'hDEADBEEF);
        write = 1'b1;
        for (int a = 1; a < 16; a++) begin
            rd = 4'(a); wdata = 16'h1000 + 16'(a);
            tick();
        end
        write = 1'b0; rs1 = 4'd15; rs2 = 4'd9;
        tick();
        check("fill_r15", {16'h0, n_reg1}, 32'h100F);
        check("fill_r9", {16'h0, z_reg2}, 32'h1009);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_ready", {31'h0, z_ready}, 32'h0);
        reset = 1'b1;
        tick();
        check("rerst_reg1", {16'h0, n_reg1}, 32'h0);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("re_ready_%0d", i), {31'h0, n_ready}, {31'h0, i == 16});
        end
        for (int a = 0; a < 16; a++) begin
            rs1 = 4'(a); rs2 = 4'(15 - a);
            tick();
            check($sformatf("re_n1_%0d", a), {16'h0, n_reg1}, 32'h0);
            check($sformatf("re_z2_%0d", a), {16'h0, z_reg2}, 32'h0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
